bt_cmd_decoder: RTL and testbench

Downstream consumer of the Bluetooth UART receiver, which delivers one byte per strobe. It parses framed command packets from the phone app into song selection, play/stop control and live piano-key events for the game/audio core. Malformed frames, checksum failures and stalled frames are rejected without disturbing the current outputs.

---
 rtl/bt_cmd_pkg.sv | 9 +
 rtl/bt_timeout_cnt.sv | 16 +
 rtl/bt_cmd_decoder.sv | 102 ++++++++++
 tb/tb_bt_cmd_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_cmd_pkg.sv
// bt_cmd_pkg: frame header, opcodes and FSM states shared by the command decoder.
package bt_cmd_pkg;
  localparam logic [7:0] BT_HDR    = 8'hAA;
  localparam logic [7:0] OP_SELECT = 8'h01;
  localparam logic [7:0] OP_PLAY   = 8'h02;
  localparam logic [7:0] OP_STOP   = 8'h03;
  localparam logic [7:0] OP_KEY    = 8'h04;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ARG, S_CHK} state_e;
endpackage

// File: rtl/bt_timeout_cnt.sv
// bt_timeout_cnt: counts idle cycles while run is high; expire pulses on the LIMIT-th idle cycle.
module bt_timeout_cnt #(
  parameter int LIMIT = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expire
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign expire = run & ~clr & (cnt_q == W'(LIMIT - 1));
  always_comb cnt_d = (!run || clr || expire) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: parses AA/CMD/ARG[/CHK] frames into song, play and key events.
// Define BT_CMD_CHECKSUM_EN for 4-byte frames with CHK = CMD ^ ARG; otherwise 3-byte frames.
module bt_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int NUM_SONGS      = 10,
  parameter int NUM_KEYS       = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] choose,
  output logic       playing,
  output logic       key_valid,
  output logic [4:0] key_code,
  output logic       err,
  output logic       busy
);
  localparam logic [7:0] SONG_LIM = 8'(NUM_SONGS);
  localparam logic [7:0] KEY_LIM  = 8'(NUM_KEYS);
  state_e state_q, state_d;
  logic [7:0] cmd_q, cmd_d, fin_arg;
  logic [3:0] choose_q, choose_d;
  logic [4:0] key_code_q, key_code_d;
  logic playing_q, playing_d, key_valid_q, key_valid_d, err_q, err_d;
  logic expire, last, legal, chk_ok, exec;
`ifdef BT_CMD_CHECKSUM_EN
  logic [7:0] arg_q, arg_d;
  assign last    = rx_valid && state_q == S_CHK;
  assign fin_arg = arg_q;
  assign chk_ok  = rx_data == (cmd_q ^ arg_q);
  always_ff @(posedge clk) arg_q <= rst ? '0 : arg_d;
`else
  assign last    = rx_valid && state_q == S_ARG;
  assign fin_arg = rx_data;
  assign chk_ok  = 1'b1;
`endif
  assign busy  = state_q != S_IDLE;
  assign legal = (cmd_q == OP_SELECT && fin_arg < SONG_LIM) || cmd_q == OP_PLAY ||
                 cmd_q == OP_STOP || (cmd_q == OP_KEY && fin_arg < KEY_LIM);
  assign exec  = last && legal && chk_ok;
  bt_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk), .rst(rst), .run(busy), .clr(rx_valid), .expire(expire)
  );
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
`ifdef BT_CMD_CHECKSUM_EN
    arg_d   = arg_q;
`endif
    if (rx_valid) begin
      case (state_q)
        S_IDLE: state_d = rx_data == BT_HDR ? S_CMD : S_IDLE;
        S_CMD: begin
          cmd_d   = rx_data;
          state_d = S_ARG;
        end
`ifdef BT_CMD_CHECKSUM_EN
        S_ARG: begin
          arg_d   = rx_data;
          state_d = S_CHK;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (expire) begin
      state_d = S_IDLE;
    end
    err_d       = (last && !exec) || expire;
    key_valid_d = exec && cmd_q == OP_KEY;
    key_code_d  = key_valid_d ? fin_arg[4:0] : key_code_q;
    choose_d    = exec && cmd_q == OP_SELECT ? fin_arg[3:0] : choose_q;
    playing_d   = !exec ? playing_q : cmd_q == OP_PLAY ? 1'b1 :
                  (cmd_q == OP_SELECT || cmd_q == OP_STOP) ? 1'b0 : playing_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      choose_q    <= '0;
      playing_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      choose_q    <= choose_d;
      playing_q   <= playing_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      err_q       <= err_d;
    end
  end
  assign choose    = choose_q;
  assign playing   = playing_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign err       = err_q;
endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb_bt_cmd_decoder: directed scenario tasks for bt_cmd_decoder with a 50-cycle timeout.
module tb_bt_cmd_decoder;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [3:0] choose;
  logic playing, key_valid, err, busy;
  logic [4:0] key_code;
  int tests = 0, fails = 0;

  bt_cmd_decoder #(.TIMEOUT_CYCLES(50), .NUM_SONGS(10), .NUM_KEYS(21)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .choose(choose),
    .playing(playing), .key_valid(key_valid), .key_code(key_code), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a);
    send_byte(8'hAA);
    send_byte(c);
    send_byte(a);
`ifdef BT_CMD_CHECKSUM_EN
    send_byte(c ^ a);
`endif
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({choose, playing, key_valid, key_code, err, busy} !== 13'd0) begin
      fails++;
      $display("FAIL reset: got %b want 0", {choose, playing, key_valid, key_code, err, busy});
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_select;
    send_byte(8'hAA);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_hdr: got %b want 1", busy);
    end
    send_byte(8'h01);
    send_byte(8'h03);
`ifdef BT_CMD_CHECKSUM_EN
    send_byte(8'h02);
`endif
    @(negedge clk);
    tests++;
    if ({choose, playing, err, busy} !== {4'd3, 3'b000}) begin
      fails++;
      $display("FAIL select: got ch=%0d pl=%b err=%b busy=%b want ch=3 pl=0 err=0 busy=0", choose, playing, err, busy);
    end
  endtask

  task automatic test_play_key;
    send_frame(8'h02, 8'h00);
    @(negedge clk);
    tests++;
    if ({playing, key_valid, err} !== 3'b100) begin
      fails++;
      $display("FAIL play: got pl=%b kv=%b err=%b want 1 0 0", playing, key_valid, err);
    end
    send_frame(8'h04, 8'h07);
    @(negedge clk);
    tests++;
    if ({key_valid, key_code, err, playing} !== {1'b1, 5'd7, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL key: got kv=%b kc=%0d err=%b pl=%b want 1 7 0 1", key_valid, key_code, err, playing);
    end
    @(negedge clk);
    tests++;
    if ({key_valid, key_code} !== {1'b0, 5'd7}) begin
      fails++;
      $display("FAIL key_pulse_width: got kv=%b kc=%0d want 0 7", key_valid, key_code);
    end
  endtask

  task automatic test_rejects;
`ifdef BT_CMD_CHECKSUM_EN
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h05);
    @(negedge clk);
    tests++;
    if ({err, key_valid, choose, playing, busy} !== {2'b10, 4'd3, 2'b10}) begin
      fails++;
      $display("FAIL bad_chk: got err=%b kv=%b ch=%0d pl=%b busy=%b want 1 0 3 1 0", err, key_valid, choose, playing, busy);
    end
`endif
    send_frame(8'h01, 8'h0C);
    @(negedge clk);
    tests++;
    if ({err, choose, playing, busy} !== {1'b1, 4'd3, 2'b10}) begin
      fails++;
      $display("FAIL song_range: got err=%b ch=%0d pl=%b busy=%b want 1 3 1 0", err, choose, playing, busy);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_width: got %b want 0", err);
    end
    send_frame(8'h09, 8'h00);
    @(negedge clk);
    tests++;
    if ({err, key_valid, choose, playing} !== {2'b10, 4'd3, 1'b1}) begin
      fails++;
      $display("FAIL bad_opcode: got err=%b kv=%b ch=%0d pl=%b want 1 0 3 1", err, key_valid, choose, playing);
    end
  endtask

  task automatic test_stray;
    logic seen = 1'b0;
    send_byte(8'h55);
    @(negedge clk);
    seen |= err | busy;
    send_byte(8'h13);
    @(negedge clk);
    seen |= err | busy;
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL stray: got err_or_busy=%b want 0", seen);
    end
    send_frame(8'h03, 8'h00);
    @(negedge clk);
    tests++;
    if ({playing, err, busy} !== 3'b000) begin
      fails++;
      $display("FAIL stop_after_stray: got pl=%b err=%b busy=%b want 0 0 0", playing, err, busy);
    end
  endtask

  task automatic test_timeout;
    logic early = 1'b0;
    send_byte(8'hAA);
    send_byte(8'h01);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      early |= err | ~busy;
      @(posedge clk);
    end
    tests++;
    if (early !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: got early=%b want 0", early);
    end
    @(negedge clk);
    tests++;
    if ({err, busy} !== 2'b10) begin
      fails++;
      $display("FAIL timeout: got err=%b busy=%b want 1 0", err, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout_race;
    logic early = 1'b0;
    send_byte(8'hAA);
    send_byte(8'h01);
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      early |= err;
      @(posedge clk);
    end
    #1;
    send_byte(8'h03);
    @(negedge clk);
    early |= err;
    tests++;
`ifdef BT_CMD_CHECKSUM_EN
    if ({early, busy} !== 2'b01) begin
      fails++;
      $display("FAIL race_arg: got err=%b busy=%b want 0 1", early, busy);
    end
    send_byte(8'h02);
    @(negedge clk);
    tests++;
`endif
    if ({early, err, choose, playing, busy} !== {2'b00, 4'd3, 2'b00}) begin
      fails++;
      $display("FAIL race_exec: got err=%b ch=%0d pl=%b busy=%b want 0 3 0 0", early | err, choose, playing, busy);
    end
  endtask

  task automatic test_reset_mid;
    send_byte(8'hAA);
    send_byte(8'h04);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, err, key_code, choose} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b err=%b kc=%0d ch=%0d want 0 0 0 0", busy, err, key_code, choose);
    end
    send_frame(8'h04, 8'h05);
    @(negedge clk);
    tests++;
    if ({key_valid, key_code, err} !== {1'b1, 5'd5, 1'b0}) begin
      fails++;
      $display("FAIL key_after_reset: got kv=%b kc=%0d err=%b want 1 5 0", key_valid, key_code, err);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h01, 8'h05);
    send_frame(8'h04, 8'h02);
    @(negedge clk);
    tests++;
    if ({choose, key_valid, key_code, err, busy, playing} !== {4'd5, 1'b1, 5'd2, 3'b000}) begin
      fails++;
      $display("FAIL back_to_back: got ch=%0d kv=%b kc=%0d err=%b busy=%b pl=%b want 5 1 2 0 0 0", choose, key_valid, key_code, err, busy, playing);
    end
  endtask

  initial begin
    test_reset;
    test_select;
    test_play_key;
    test_rejects;
    test_stray;
    test_timeout;
    test_timeout_race;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
